// File: rtl/wta_pkg.sv
// Shared types and helpers for the winner-take-all gamma-cycle sequencer.
// Lane helpers take a fixed 64-bit vector; callers zero-extend narrower lanes.
package wta_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, WINDOW} gamma_state_t;

  localparam int MAX_LANES = 64;
  localparam int IDX_W     = 6;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [IDX_W-1:0] lowest_set_idx(input logic [MAX_LANES-1:0] v);
    lowest_set_idx = '0;
    for (int i = MAX_LANES - 1; i >= 0; i--) begin
      if (v[i]) lowest_set_idx = IDX_W'(i);
    end
  endfunction

  // True when more than one bit is set (clearing the lowest set bit leaves something).
  function automatic logic onehot_multi(input logic [MAX_LANES-1:0] v);
    return (v & (v - MAX_LANES'(1))) != '0;
  endfunction

endpackage

// File: rtl/wta_gamma_ctrl_spike_sync.sv
// Multi-stage synchroniser for the asynchronous WTA spike lanes.
module spike_sync #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  // NOTE: every stage is reset so the sampled lanes start from a known all-clear
  // value; a register array that is not reset would power up as X in simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d};
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/wta_gamma_ctrl.sv
// Gamma-cycle sequencer: clears the WTA, samples its synchronised spikes,
// captures the first winner and publishes it through a valid/ready interface.
module wta_gamma_ctrl
  import wta_pkg::*;
#(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int NUM_INPUTS        = 16,
  parameter int RST_CYCLES        = 2,
  parameter int SYNC_STAGES       = 2,
  parameter bit FALLING           = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 enable,
  input  logic                                 clr_status,
  output logic                                 wta_rst,
  input  logic [NUM_INPUTS-1:0]                wta_spikes,
  output logic                                 gamma_start,
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic [$clog2(NUM_INPUTS)-1:0]        res_idx,
  output logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0] res_time,
  output logic                                 res_none,
  output logic                                 res_multi,
  output logic                                 overrun
);

  localparam int CW = $clog2(GAMMA_CYCLE_WIDTH);
  localparam int IW = $clog2(NUM_INPUTS);
  localparam logic [CW-1:0] CNT_LAST = CW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(RST_CYCLES - 1);

  gamma_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          publish;
  logic          start_nxt;

  logic [NUM_INPUTS-1:0] s_sync;
  logic [NUM_INPUTS-1:0] s;

  logic          captured;
  logic [IW-1:0] cap_idx;
  logic [CW-1:0] cap_time;
  logic          cap_multi;

  logic          hit;
  logic [IW-1:0] hit_idx;
  logic          hit_multi;
  logic [IW-1:0] pub_idx;
  logic [CW-1:0] pub_time;
  logic          pub_multi;
  logic          pub_none;

  spike_sync #(
    .WIDTH  (NUM_INPUTS),
    .STAGES (SYNC_STAGES)
  ) u_spike_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (wta_spikes),
    .q     (s_sync)
  );

  assign s       = s_sync ^ {NUM_INPUTS{FALLING}};
  assign wta_rst = (state != WINDOW);

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    publish   = 1'b0;
    start_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (enable) begin
          state_nxt = CLEAR;
          start_nxt = 1'b1;
        end
      end
      CLEAR: begin
        cnt_nxt = cnt + CW'(1);
        if (cnt == CLR_LAST) state_nxt = WINDOW;
      end
      WINDOW: begin
        if (cnt == CNT_LAST) begin
          publish = 1'b1;
          cnt_nxt = '0;
          if (enable) begin
            state_nxt = CLEAR;
            start_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of the order the statements appear in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      gamma_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      gamma_start <= start_nxt;
    end
  end

  assign hit       = (state == WINDOW) && !captured && (s != '0);
  assign hit_idx   = IW'(lowest_set_idx(MAX_LANES'(s)));
  assign hit_multi = onehot_multi(MAX_LANES'(s));

  // A spike first seen on the terminal clock still makes it into that cycle's result.
  assign pub_none  = !(captured || hit);
  assign pub_idx   = captured ? cap_idx   : (hit ? hit_idx   : '0);
  assign pub_time  = captured ? cap_time  : (hit ? cnt       : '0);
  assign pub_multi = captured ? cap_multi : (hit ? hit_multi : 1'b0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      captured  <= 1'b0;
      cap_idx   <= '0;
      cap_time  <= '0;
      cap_multi <= 1'b0;
    end else if (state != WINDOW) begin
      captured  <= 1'b0;
    end else if (hit) begin
      captured  <= 1'b1;
      cap_idx   <= hit_idx;
      cap_time  <= cnt;
      cap_multi <= hit_multi;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_idx   <= '0;
      res_time  <= '0;
      res_none  <= 1'b0;
      res_multi <= 1'b0;
    end else if (publish) begin
      res_valid <= 1'b1;
      res_idx   <= pub_idx;
      res_time  <= pub_time;
      res_none  <= pub_none;
      res_multi <= pub_multi;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

  // Setting beats clearing when both land on the same clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (publish && res_valid && !res_ready) begin
      overrun <= 1'b1;
    end else if (clr_status) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wta_gamma_ctrl.sv
// Self-checking bench for wta_gamma_ctrl: directed and randomized gamma cycles
// against a transaction-level model, plus an active-low (FALLING) instance.
module tb_wta_gamma_ctrl;

  localparam int GCW  = 16;
  localparam int NI   = 16;
  localparam int RSTC = 2;
  localparam int SYNC = 2;
  localparam int CW   = $clog2(GCW);
  localparam int IW   = $clog2(NI);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable, clr_status, res_ready;
  logic [NI-1:0] spikes;
  logic          wta_rst, gamma_start, res_valid, res_none, res_multi, overrun;
  logic [IW-1:0] res_idx;
  logic [CW-1:0] res_time;

  logic          enable_f, clr_status_f, res_ready_f;
  logic [NI-1:0] spikes_f;
  logic          wta_rst_f, gamma_start_f, res_valid_f, res_none_f, res_multi_f, overrun_f;
  logic [IW-1:0] res_idx_f;
  logic [CW-1:0] res_time_f;

  always #5 clk = ~clk;

  wta_gamma_ctrl #(
    .GAMMA_CYCLE_WIDTH (GCW), .NUM_INPUTS (NI), .RST_CYCLES (RSTC),
    .SYNC_STAGES (SYNC), .FALLING (1'b0)
  ) dut (
    .clk (clk), .rst_n (rst_n), .enable (enable), .clr_status (clr_status),
    .wta_rst (wta_rst), .wta_spikes (spikes), .gamma_start (gamma_start),
    .res_valid (res_valid), .res_ready (res_ready), .res_idx (res_idx),
    .res_time (res_time), .res_none (res_none), .res_multi (res_multi),
    .overrun (overrun)
  );

  wta_gamma_ctrl #(
    .GAMMA_CYCLE_WIDTH (GCW), .NUM_INPUTS (NI), .RST_CYCLES (RSTC),
    .SYNC_STAGES (SYNC), .FALLING (1'b1)
  ) dut_f (
    .clk (clk), .rst_n (rst_n), .enable (enable_f), .clr_status (clr_status_f),
    .wta_rst (wta_rst_f), .wta_spikes (spikes_f), .gamma_start (gamma_start_f),
    .res_valid (res_valid_f), .res_ready (res_ready_f), .res_idx (res_idx_f),
    .res_time (res_time_f), .res_none (res_none_f), .res_multi (res_multi_f),
    .overrun (overrun_f)
  );

  int checks = 0;
  int errors = 0;

  // Model of the published result register and the result of the cycle in flight.
  bit m_valid, m_none, m_multi, m_over;
  int m_idx, m_time;
  bit n_none, n_multi;
  int n_idx, n_time;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_none = 0; m_multi = 0; m_over = 0; m_idx = 0; m_time = 0;
  endtask

  task automatic model_edge(input bit pub, input bit rdy, input bit clr);
    if (pub) begin
      if (m_valid && !rdy) m_over = 1;
      else if (clr)        m_over = 0;
      m_valid = 1; m_idx = n_idx; m_time = n_time; m_none = n_none; m_multi = n_multi;
    end else begin
      if (m_valid && rdy) m_valid = 0;
      if (clr)            m_over  = 0;
    end
  endtask

  // Expected result for a pattern raised at a given cycle count: it becomes
  // visible SYNC_STAGES clocks later, if that is still inside the cycle.
  task automatic predict(input logic [NI-1:0] pat, input int at);
    n_idx = 0; n_time = 0; n_multi = 0; n_none = 1;
    if (pat != '0 && at + SYNC <= GCW - 1) begin
      n_none  = 0;
      n_time  = at + SYNC;
      n_multi = ($countones(pat) > 1);
      for (int i = NI - 1; i >= 0; i--) if (pat[i]) n_idx = i;
    end
  endtask

  task automatic check_outs(input bit exp_rst, input bit exp_gs, input string tag);
    chk({tag, " wta_rst"},     32'(wta_rst),     32'(exp_rst));
    chk({tag, " gamma_start"}, 32'(gamma_start), 32'(exp_gs));
    chk({tag, " res_valid"},   32'(res_valid),   32'(m_valid));
    chk({tag, " res_idx"},     32'(res_idx),     32'(m_idx));
    chk({tag, " res_time"},    32'(res_time),    32'(m_time));
    chk({tag, " res_none"},    32'(res_none),    32'(m_none));
    chk({tag, " res_multi"},   32'(res_multi),   32'(m_multi));
    chk({tag, " overrun"},     32'(overrun),     32'(m_over));
  endtask

  task automatic wait_gs(input string tag);
    bit seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk);
      model_edge(0, res_ready, clr_status);
      @(negedge clk);
      seen = gamma_start;
    end
    chk({tag, " gamma_start within bound"}, 32'(seen), 32'(1));
  endtask

  // Runs one gamma cycle starting at the negedge of cnt = 0; -1 disables an option.
  task automatic run_cycle(input logic [NI-1:0] pat, input int at,
                           input logic [NI-1:0] late, input int late_at,
                           input bit rdy_body, input bit rdy_pub,
                           input int clr_at, input int drop_at, input int rst_at,
                           input string tag);
    predict(pat, at);
    for (int c = 0; c < GCW; c++) begin
      if (c > 0) check_outs(c < RSTC, 0, $sformatf("%s c%0d", tag, c));
      if (c == rst_at) begin
        rst_n = 0;
        #1;
        model_reset();
        check_outs(1, 0, {tag, " async reset"});
        return;
      end
      if (c == 0)       spikes = '0;
      if (c == at)      spikes = spikes | pat;
      if (c == late_at) spikes = spikes | late;
      if (c == drop_at) enable = 0;
      res_ready  = (c == GCW - 1) ? rdy_pub : rdy_body;
      clr_status = (c == clr_at);
      @(posedge clk);
      model_edge(c == GCW - 1, res_ready, clr_status);
      @(negedge clk);
    end
    clr_status = 0;
    check_outs(1, enable, {tag, " publish"});
  endtask

  initial begin
    logic [NI-1:0] pat;
    int            at;
    bit            seen_f;

    rst_n = 0; enable = 0; clr_status = 0; res_ready = 0; spikes = '0;
    enable_f = 0; clr_status_f = 0; res_ready_f = 1; spikes_f = '1;
    model_reset();
    n_idx = 0; n_time = 0; n_none = 0; n_multi = 0;

    #2;
    check_outs(1, 0, "reset");
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      model_edge(0, res_ready, clr_status);
      @(negedge clk);
      check_outs(1, 0, "idle");
    end

    enable = 1; res_ready = 1;
    wait_gs("start");
    check_outs(1, 1, "start");

    run_cycle(16'h0020, 4, '0, -1, 1, 1, -1, -1, -1, "single");
    run_cycle(16'h0208, 5, 16'h0002, 7, 1, 1, -1, -1, -1, "simul");
    run_cycle('0, -1, '0, -1, 1, 1, -1, -1, -1, "none");

    for (int k = 0; k < 6; k++) begin
      pat = NI'($urandom);
      if (k % 2 == 0) pat = NI'(1) << $urandom_range(0, NI - 1);
      at = $urandom_range(0, GCW - 1 - SYNC - 1);
      run_cycle(pat, at, NI'($urandom), at + 1, 1, 1, -1, -1, -1, $sformatf("rand%0d", k));
    end

    run_cycle(16'h0004, 6, '0, -1, 0, 0, -1, -1, -1, "bp_a");
    run_cycle(16'h0800, 2, '0, -1, 0, 0, -1, -1, -1, "bp_b");
    run_cycle(16'h0101, 9, '0, -1, 0, 1, 5, -1, -1, "bp_clr_then_ready");
    run_cycle(16'h8000, 3, '0, -1, 0, 0, 15, -1, -1, "bp_set_wins");
    run_cycle(16'h0040, 1, '0, -1, 1, 1, 3, -1, -1, "bp_clear");

    run_cycle(16'h0010, 7, '0, -1, 1, 1, -1, 8, -1, "drop");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      model_edge(0, res_ready, clr_status);
      @(negedge clk);
      check_outs(1, 0, "post_drop idle");
    end

    enable = 1;
    wait_gs("restart");
    check_outs(1, 1, "restart");
    run_cycle(16'h0080, 3, '0, -1, 0, 0, -1, -1, -1, "pending");
    run_cycle(16'h0001, 2, '0, -1, 0, 0, -1, -1, 10, "mid_reset");
    enable = 0;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      model_edge(0, res_ready, clr_status);
      @(negedge clk);
      check_outs(1, 0, "post_reset idle");
    end

    // Active-low instance: lanes idle high, lane 2 falls at cnt = 3.
    enable_f = 1;
    seen_f = 0;
    for (int i = 0; i < 8 && !seen_f; i++) begin
      @(negedge clk);
      seen_f = gamma_start_f;
    end
    chk("falling gamma_start within bound", 32'(seen_f), 32'(1));
    for (int c = 0; c < GCW; c++) begin
      if (c == 3) spikes_f = ~NI'(16'h0004);
      @(negedge clk);
    end
    chk("falling res_valid", 32'(res_valid_f), 32'(1));
    chk("falling res_idx",   32'(res_idx_f),   32'(2));
    chk("falling res_time",  32'(res_time_f),  32'(3 + SYNC));
    chk("falling res_none",  32'(res_none_f),  32'(0));
    chk("falling res_multi", 32'(res_multi_f), 32'(0));
    enable_f = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
